// File: rtl/i2c_slave_pkg.sv
// I2C target shared definitions: FSM states, LB register map, STATUS field positions.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package i2c_slave_pkg;

  typedef enum logic [3:0] {
    IDLE_S      = 4'd0,
    ADDR_S      = 4'd1,
    ADDR_ACK_S  = 4'd2,
    PTR_S       = 4'd3,
    PTR_ACK_S   = 4'd4,
    WDATA_S     = 4'd5,
    WDATA_ACK_S = 4'd6,
    RDATA_S     = 4'd7,
    MACK_S      = 4'd8,
    WAIT_S      = 4'd9
  } state_e;

  // Local-bus register map
  localparam logic [7:0] LB_STATUS_A = 8'h00;
  localparam logic [7:0] LB_PTR_A    = 8'h01;
  localparam logic [7:0] LB_BANK_A   = 8'h10;

  // STATUS field positions
  localparam int ST_BUSY_B    = 0;
  localparam int ST_RDNWR_B   = 1;
  localparam int ST_STOP_B    = 2;
  localparam int ST_FSM_LSB   = 3;
  localparam int ST_RXCNT_LSB = 8;

  // 8-bit counter increment that sticks at 0xFF
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/i2c_bus_mon.sv
// I2C bus monitor: synchronises SCL/SDA and flags SCL edges and START/STOP conditions.
// Latency: 3 clk from pin change to registered action on the event (2 sync + 1 edge reg).
// Backpressure: none; events are single-cycle pulses that must be consumed immediately.
module i2c_bus_mon (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_det_o,
  output logic stop_det_p_o,
  output logic sda_s_o
);

  logic [1:0] scl_sync_q;
  logic [1:0] sda_sync_q;
  logic       scl_prev_q;
  logic       sda_prev_q;
  logic       scl_s;
  logic       sda_s;

  // Two-flop synchronisers plus one history stage; reset to idle-bus level so no spurious events
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_prev_q <= scl_sync_q[1];
      sda_prev_q <= sda_sync_q[1];
    end
  end

  assign scl_s = scl_sync_q[1];
  assign sda_s = sda_sync_q[1];

  assign scl_rise_o   = scl_s & ~scl_prev_q;
  assign scl_fall_o   = ~scl_s & scl_prev_q;
  // SDA edges only count as START/STOP when SCL was high on both sides of the edge
  assign start_det_o  = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det_p_o = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  assign sda_s_o      = sda_s;

endmodule

// File: rtl/i2c_slave.sv
// I2C target with pointer-addressed byte bank, also readable/writable from the local bus.
// Latency: LB ack 1 clk after strobe; I2C actions 3 clk after pin edges, SDA driven 1 clk after a detected SCL fall.
// Backpressure: none; LB strobes are always accepted, I2C flow is paced by the master's SCL.
module i2c_slave
  import i2c_slave_pkg::*;
#(
  parameter int         LB_DATA_W  = 32,
  parameter int         LB_ADDR_W  = 8,
  parameter logic [6:0] SLAVE_ADDR = 7'h1A,
  parameter int         NUM_REGS   = 16,
  parameter logic       ACK_VAL    = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 lb_wr_en_i,
  input  logic                 lb_rd_en_i,
  input  logic [LB_ADDR_W-1:0] lb_addr_i,
  input  logic [LB_DATA_W-1:0] lb_wr_data_i,
  output logic                 lb_wr_valid_o,
  output logic                 lb_rd_valid_o,
  output logic [LB_DATA_W-1:0] lb_rd_data_o,
  input  logic                 scl_i,
  inout  wire                  sda_io
);

  localparam int PW = $clog2(NUM_REGS);

  logic                 scl_rise, scl_fall, start_det, stop_det_p, sda_s;

  state_e               state_q;
  logic [3:0]           bit_cnt_q;
  logic [7:0]           shift_q;
  logic [PW-1:0]        ptr_q;
  logic [7:0]           bank_q [NUM_REGS];
  logic                 ack_ph_q;
  logic                 sda_oe_q;
  logic [7:0]           rx_cnt_q;
  logic                 stop_det_q;
  logic                 rd_n_wr_q;
  logic                 lb_wr_valid_q;
  logic                 lb_rd_valid_q;
  logic [LB_DATA_W-1:0] lb_rd_data_q;

  logic [7:0]           rx_byte_d;
  logic [PW-1:0]        ptr_nxt_d;
  logic [LB_ADDR_W-1:0] bank_off_d;
  logic                 bank_hit_d;
  logic [PW-1:0]        bank_idx_d;
  logic                 status_rd_d;
  logic                 ptr_wr_d;
  logic                 busy_d;
  logic [LB_DATA_W-1:0] rd_mux_d;
  logic                 unused_ok;

  i2c_bus_mon u_bus_mon (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .scl_i        (scl_i),
    .sda_i        (sda_io),
    .scl_rise_o   (scl_rise),
    .scl_fall_o   (scl_fall),
    .start_det_o  (start_det),
    .stop_det_p_o (stop_det_p),
    .sda_s_o      (sda_s)
  );

  assign rx_byte_d   = {shift_q[6:0], sda_s};
  assign ptr_nxt_d   = ptr_q + PW'(1);
  assign busy_d      = (state_q != IDLE_S) && (state_q != WAIT_S);
  assign bank_off_d  = lb_addr_i - LB_ADDR_W'(LB_BANK_A);
  assign bank_hit_d  = (lb_addr_i >= LB_ADDR_W'(LB_BANK_A)) && (bank_off_d < LB_ADDR_W'(NUM_REGS));
  assign bank_idx_d  = bank_off_d[PW-1:0];
  assign status_rd_d = lb_rd_en_i && (lb_addr_i == LB_ADDR_W'(LB_STATUS_A));
  assign ptr_wr_d    = lb_wr_en_i && (lb_addr_i == LB_ADDR_W'(LB_PTR_A)) && !busy_d;
  assign unused_ok   = ^{lb_wr_data_i[LB_DATA_W-1:8], bank_off_d[LB_ADDR_W-1:PW]};

  // LB read decode; unmapped addresses read as zero
  always_comb begin
    rd_mux_d = '0;
    if (lb_addr_i == LB_ADDR_W'(LB_STATUS_A)) begin
      rd_mux_d[ST_RXCNT_LSB +: 8] = rx_cnt_q;
      rd_mux_d[ST_FSM_LSB +: 4]   = state_q;
      rd_mux_d[ST_STOP_B]         = stop_det_q;
      rd_mux_d[ST_RDNWR_B]        = rd_n_wr_q;
      rd_mux_d[ST_BUSY_B]         = busy_d;
    end else if (lb_addr_i == LB_ADDR_W'(LB_PTR_A)) begin
      rd_mux_d[PW-1:0] = ptr_q;
    end else if (bank_hit_d) begin
      rd_mux_d[7:0] = bank_q[bank_idx_d];
    end
  end

  // Protocol FSM, bank and LB side; I2C updates come last so they win any same-cycle LB collision
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= IDLE_S;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      ptr_q         <= '0;
      ack_ph_q      <= 1'b0;
      sda_oe_q      <= 1'b0;
      rx_cnt_q      <= '0;
      stop_det_q    <= 1'b0;
      rd_n_wr_q     <= 1'b0;
      lb_wr_valid_q <= 1'b0;
      lb_rd_valid_q <= 1'b0;
      lb_rd_data_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) bank_q[i] <= '0;
    end else begin
      lb_wr_valid_q <= lb_wr_en_i;
      lb_rd_valid_q <= lb_rd_en_i;
      lb_rd_data_q  <= lb_rd_en_i ? rd_mux_d : '0;

      if (status_rd_d) begin
        stop_det_q <= 1'b0;
        rx_cnt_q   <= '0;
      end
      if (lb_wr_en_i && bank_hit_d) bank_q[bank_idx_d] <= lb_wr_data_i[7:0];
      if (ptr_wr_d) ptr_q <= lb_wr_data_i[PW-1:0];

      if (stop_det_p) begin
        state_q    <= IDLE_S;
        sda_oe_q   <= 1'b0;
        stop_det_q <= 1'b1;
      end else if (start_det) begin
        state_q   <= ADDR_S;
        bit_cnt_q <= '0;
        ack_ph_q  <= 1'b0;
        sda_oe_q  <= 1'b0;
      end else begin
        case (state_q)
          ADDR_S, PTR_S, WDATA_S: begin
            if (scl_rise) begin
              shift_q <= rx_byte_d;
              if (bit_cnt_q == 4'd7) begin
                bit_cnt_q <= '0;
                ack_ph_q  <= 1'b0;
                if (state_q == ADDR_S) begin
                  if (rx_byte_d[7:1] == SLAVE_ADDR) begin
                    rd_n_wr_q <= rx_byte_d[0];
                    state_q   <= ADDR_ACK_S;
                  end else begin
                    state_q <= WAIT_S;
                  end
                end else if (state_q == PTR_S) begin
                  ptr_q   <= rx_byte_d[PW-1:0];
                  state_q <= PTR_ACK_S;
                end else begin
                  bank_q[ptr_q] <= rx_byte_d;
                  ptr_q         <= ptr_nxt_d;
                  rx_cnt_q      <= status_rd_d ? 8'd1 : sat_inc8(rx_cnt_q);
                  state_q       <= WDATA_ACK_S;
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end
            end
          end
          ADDR_ACK_S, PTR_ACK_S, WDATA_ACK_S: begin
            // First fall starts the ACK bit, second fall ends it
            if (scl_fall) begin
              if (!ack_ph_q) begin
                ack_ph_q <= 1'b1;
                sda_oe_q <= ~ACK_VAL;
              end else begin
                ack_ph_q  <= 1'b0;
                bit_cnt_q <= '0;
                if (state_q == ADDR_ACK_S && rd_n_wr_q) begin
                  // The ACK-ending fall is also the start of the first read bit
                  sda_oe_q  <= ~bank_q[ptr_q][7];
                  shift_q   <= {bank_q[ptr_q][6:0], 1'b0};
                  bit_cnt_q <= 4'd1;
                  state_q   <= RDATA_S;
                end else begin
                  sda_oe_q <= 1'b0;
                  state_q  <= (state_q == ADDR_ACK_S) ? PTR_S : WDATA_S;
                end
              end
            end
          end
          RDATA_S: begin
            if (scl_fall) begin
              if (bit_cnt_q == 4'd8) begin
                sda_oe_q <= 1'b0;
                state_q  <= MACK_S;
              end else begin
                sda_oe_q  <= ~shift_q[7];
                shift_q   <= {shift_q[6:0], 1'b0};
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end
            end
          end
          MACK_S: begin
            if (scl_rise) begin
              if (sda_s == ACK_VAL) begin
                ptr_q     <= ptr_nxt_d;
                shift_q   <= bank_q[ptr_nxt_d];
                bit_cnt_q <= '0;
                state_q   <= RDATA_S;
              end else begin
                state_q <= WAIT_S;
              end
            end
          end
          default: sda_oe_q <= 1'b0;
        endcase
      end
    end
  end

  assign lb_wr_valid_o = lb_wr_valid_q;
  assign lb_rd_valid_o = lb_rd_valid_q;
  assign lb_rd_data_o  = lb_rd_data_q;

  // Open-drain: only ever pull low
  assign sda_io = sda_oe_q ? 1'b0 : 1'bz;

endmodule
